// File: rtl/dom_rand_pkg.sv
// Shared constants, types and the LFSR feedback helper for the 3-share DOM
// randomness feeder.
package dom_rand_pkg;

  localparam int unsigned LFSR_W     = 32;
  localparam int unsigned STEP_BITS  = 8;
  localparam int unsigned N_SHARES   = 3;
  localparam int unsigned N_PRAND    = 3;
  localparam int unsigned CNT_W      = 2;

  // Taps of x^32 + x^22 + x^2 + x + 1 for a left-shifting Fibonacci register.
  localparam int unsigned TAP_0 = 31;
  localparam int unsigned TAP_1 = 21;
  localparam int unsigned TAP_2 = 1;
  localparam int unsigned TAP_3 = 0;

  // Which post-step LFSR bit feeds which share / p_rand output.
  localparam int unsigned RIDX_A_S1 = 0;
  localparam int unsigned RIDX_A_S2 = 1;
  localparam int unsigned RIDX_B_S1 = 2;
  localparam int unsigned RIDX_B_S2 = 3;
  localparam int unsigned RIDX_P0   = 4;
  localparam int unsigned RIDX_P1   = 5;
  localparam int unsigned RIDX_P2   = 6;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_e;

  // Index 0 is the plaintext-carrying share; 1 and 2 are the random masks.
  typedef struct packed {
    logic [N_PRAND-1:0]  p_rand;
    logic [N_SHARES-1:0] b_sh;
    logic [N_SHARES-1:0] a_sh;
  } dom_out_t;

  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
    return s[TAP_0] ^ s[TAP_1] ^ s[TAP_2] ^ s[TAP_3];
  endfunction

endpackage

// File: rtl/dom_lfsr_step8.sv
// Combinational 8-step advance of the 32-bit Fibonacci LFSR; used for both
// warm-up and run-time stepping.
module dom_lfsr_step8
  import dom_rand_pkg::*;
(
  input  logic [LFSR_W-1:0] i_state,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] w_s;

  always_comb begin
    w_s = i_state;
    for (int k = 0; k < int'(STEP_BITS); k++) begin
      w_s = {w_s[LFSR_W-2:0], lfsr_fb(w_s)};
    end
  end

  assign o_state = w_s;

endmodule

// File: rtl/dom_share_rand_gen.sv
// Masks two plaintext bits into 3-share Boolean encodings and supplies the
// DOM AND gate's three fresh random bits, all from one seedable LFSR.
module dom_share_rand_gen
  import dom_rand_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = 32'hACE1_2468,
  parameter int unsigned       WARMUP_STEPS = 4
) (
  input  logic              clock_0,
  input  logic              reset_0,
  input  logic              seed_valid,
  input  logic [LFSR_W-1:0] seed_data,
  output logic              seed_ready,
  input  logic              in_valid,
  input  logic              in_a,
  input  logic              in_b,
  output logic              in_ready,
  output logic              out_valid,
  output logic              io_i0_s0,
  output logic              io_i0_s1,
  output logic              io_i0_s2,
  output logic              io_i1_s0,
  output logic              io_i1_s1,
  output logic              io_i1_s2,
  output logic              p_rand_0,
  output logic              p_rand_1,
  output logic              p_rand_2
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARMUP_STEPS - 1);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [LFSR_W-1:0] r_lfsr;
  logic              r_ready;
  logic              r_out_valid;
  dom_out_t          r_out;

  logic [LFSR_W-1:0] w_lfsr_next;
  logic [LFSR_W-1:0] w_seed_load;
  logic              w_accept;

  dom_lfsr_step8 u_step (
    .i_state (r_lfsr),
    .o_state (w_lfsr_next)
  );

  // An all-zero seed would lock the LFSR, so substitute the default.
  assign w_seed_load = (seed_data == '0) ? SEED_DEFAULT : seed_data;
  assign w_accept    = in_valid & ~seed_valid;

  always_ff @(posedge clock_0 or negedge reset_0) begin
    if (!reset_0) begin
      r_state     <= WARMUP;
      r_cnt       <= '0;
      r_lfsr      <= SEED_DEFAULT;
      r_ready     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        WARMUP: begin
          r_lfsr <= w_lfsr_next;
          if (r_cnt == CNT_LAST) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (seed_valid) begin
            r_lfsr  <= w_seed_load;
            r_cnt   <= '0;
            r_state <= WARMUP;
            r_ready <= 1'b0;
          end else if (w_accept) begin
            // Each accept consumes seven fresh bits of a newly advanced state.
            r_lfsr         <= w_lfsr_next;
            r_out.a_sh[1]  <= w_lfsr_next[RIDX_A_S1];
            r_out.a_sh[2]  <= w_lfsr_next[RIDX_A_S2];
            r_out.a_sh[0]  <= in_a ^ w_lfsr_next[RIDX_A_S1] ^ w_lfsr_next[RIDX_A_S2];
            r_out.b_sh[1]  <= w_lfsr_next[RIDX_B_S1];
            r_out.b_sh[2]  <= w_lfsr_next[RIDX_B_S2];
            r_out.b_sh[0]  <= in_b ^ w_lfsr_next[RIDX_B_S1] ^ w_lfsr_next[RIDX_B_S2];
            r_out.p_rand   <= {w_lfsr_next[RIDX_P2], w_lfsr_next[RIDX_P1],
                               w_lfsr_next[RIDX_P0]};
            r_out_valid    <= 1'b1;
          end
        end
        default: begin
          r_state <= WARMUP;
          r_cnt   <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_ready;
  assign seed_ready = r_ready;
  assign out_valid  = r_out_valid;
  assign io_i0_s0   = r_out.a_sh[0];
  assign io_i0_s1   = r_out.a_sh[1];
  assign io_i0_s2   = r_out.a_sh[2];
  assign io_i1_s0   = r_out.b_sh[0];
  assign io_i1_s1   = r_out.b_sh[1];
  assign io_i1_s2   = r_out.b_sh[2];
  assign p_rand_0   = r_out.p_rand[0];
  assign p_rand_1   = r_out.p_rand[1];
  assign p_rand_2   = r_out.p_rand[2];

endmodule

// File: tb/tb_dom_share_rand_gen.sv
// Directed bench for dom_share_rand_gen: warm-up timing, share recombination,
// seeding, idle holding and asynchronous reset against a reference LFSR.
module tb_dom_share_rand_gen;

  localparam logic [31:0] SEED_DEF = 32'hACE1_2468;

  logic        clock_0 = 1'b0;
  logic        reset_0;
  logic        seed_valid;
  logic [31:0] seed_data;
  logic        seed_ready;
  logic        in_valid;
  logic        in_a;
  logic        in_b;
  logic        in_ready;
  logic        out_valid;
  logic        io_i0_s0, io_i0_s1, io_i0_s2;
  logic        io_i1_s0, io_i1_s1, io_i1_s2;
  logic        p_rand_0, p_rand_1, p_rand_2;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m;
  logic [8:0]  last_exp;
  logic [8:0]  ref_seq [0:7];
  logic [8:0]  w_obs;

  dom_share_rand_gen dut (
    .clock_0    (clock_0),
    .reset_0    (reset_0),
    .seed_valid (seed_valid),
    .seed_data  (seed_data),
    .seed_ready (seed_ready),
    .in_valid   (in_valid),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .io_i0_s0   (io_i0_s0),
    .io_i0_s1   (io_i0_s1),
    .io_i0_s2   (io_i0_s2),
    .io_i1_s0   (io_i1_s0),
    .io_i1_s1   (io_i1_s1),
    .io_i1_s2   (io_i1_s2),
    .p_rand_0   (p_rand_0),
    .p_rand_1   (p_rand_1),
    .p_rand_2   (p_rand_2)
  );

  always #5 clock_0 = ~clock_0;

  assign w_obs = {p_rand_2, p_rand_1, p_rand_0,
                  io_i1_s2, io_i1_s1, io_i1_s0,
                  io_i0_s2, io_i0_s1, io_i0_s0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference LFSR: tap mask 0x8020_0003 selects bits 31, 21, 1, 0.
  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    for (int i = 0; i < 8; i++) t = (t << 1) | 32'(^(t & 32'h8020_0003));
    return t;
  endfunction

  function automatic logic [8:0] ref_out(input logic [31:0] r, input logic a, input logic b);
    return {r[6], r[5], r[4], r[3], r[2], b ^ r[2] ^ r[3], r[1], r[0], a ^ r[0] ^ r[1]};
  endfunction

  task automatic tick();
    @(posedge clock_0);
    #1;
  endtask

  task automatic warmup(input string tag);
    for (int k = 0; k < 4; k++) begin
      tick();
      m = ref_step(m);
      check({tag, "_in_ready"}, 32'(in_ready), 32'(k == 3));
      check({tag, "_seed_ready"}, 32'(seed_ready), 32'(k == 3));
      check({tag, "_wu_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_wu_hold"}, 32'(w_obs), 32'(last_exp));
    end
  endtask

  task automatic accept(input string tag, input logic a, input logic b);
    in_valid   = 1'b1;
    seed_valid = 1'b0;
    in_a       = a;
    in_b       = b;
    tick();
    m        = ref_step(m);
    last_exp = ref_out(m, a, b);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_shares"}, 32'(w_obs), 32'(last_exp));
    check({tag, "_xor_a"}, 32'(io_i0_s0 ^ io_i0_s1 ^ io_i0_s2), 32'(a));
    check({tag, "_xor_b"}, 32'(io_i1_s0 ^ io_i1_s1 ^ io_i1_s2), 32'(b));
  endtask

  task automatic idle(input string tag);
    in_valid   = 1'b0;
    seed_valid = 1'b0;
    tick();
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_hold"}, 32'(w_obs), 32'(last_exp));
  endtask

  task automatic reseed(input string tag, input logic [31:0] data, input logic with_data);
    seed_valid = 1'b1;
    seed_data  = data;
    in_valid   = with_data;
    in_a       = 1'b1;
    in_b       = 1'b1;
    tick();
    seed_valid = 1'b0;
    in_valid   = 1'b0;
    m          = (data == 32'd0) ? SEED_DEF : data;
    check({tag, "_seed_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_seed_hold"}, 32'(w_obs), 32'(last_exp));
    check({tag, "_seed_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    reset_0    = 1'b0;
    seed_valid = 1'b0;
    seed_data  = 32'd0;
    in_valid   = 1'b1;
    in_a       = 1'b0;
    in_b       = 1'b0;
    last_exp   = 9'd0;
    m          = SEED_DEF;

    repeat (2) tick();
    check("rst_outputs", 32'(w_obs), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_seed_ready", 32'(seed_ready), 32'd0);
    #3 reset_0 = 1'b1;
    check("cyc0_in_ready", 32'(in_ready), 32'd0);

    // in_valid stays high through warm-up; first accept happens at cycle 4.
    warmup("boot");
    for (int i = 0; i < 16; i++) begin
      accept("run", i[0], i[1]);
      if (i < 8) ref_seq[i] = last_exp;
    end

    // Zero seed replays the post-reset sequence.
    reseed("seed0", 32'd0, 1'b0);
    warmup("seed0");
    for (int i = 0; i < 8; i++) begin
      accept("seed0_run", i[0], i[1]);
      check("seed0_replay", 32'(w_obs), 32'(ref_seq[i]));
    end

    // Seed and data offered together: seed wins, data dropped.
    reseed("seed1", 32'h0000_0001, 1'b1);
    warmup("seed1");
    for (int i = 0; i < 4; i++) accept("seed1_run", i[1], i[0]);

    // Idle gaps must not advance the LFSR or disturb the outputs.
    for (int i = 0; i < 4; i++) begin
      accept("gap_run", ~i[0], i[1]);
      repeat (3) idle("gap");
    end

    // Half-cycle async reset mid-stream.
    accept("pre_rst", 1'b1, 1'b0);
    #1 reset_0 = 1'b0;
    #1;
    check("arst_outputs", 32'(w_obs), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    #3 reset_0 = 1'b1;
    m        = SEED_DEF;
    last_exp = 9'd0;
    in_valid = 1'b1;
    warmup("rerst");
    for (int i = 0; i < 8; i++) begin
      accept("rerst_run", i[0], i[1]);
      check("rerst_replay", 32'(w_obs), 32'(ref_seq[i]));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
